// File: rtl/sync_frame_rx_pkg.sv
// Shared types and constants for the clock-sync frame receiver.
package sync_frame_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rxState_e;

  localparam logic [1:0] ERR_FRAMING = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/sync_frame_rx_if.sv
// Serial line plus byte/frame result bus of the clock-sync receiver.
interface sync_frame_rx_if #(
  parameter int N_BYTES = 7
);
  logic                   rx;
  logic [7:0]             byteData;
  logic                   byteValid;
  logic [8*N_BYTES-1:0]   frameData;
  logic                   frameValid;
  logic                   frameError;
  logic [1:0]             errCode;

  modport master (
    output rx,
    input  byteData, byteValid, frameData, frameValid, frameError, errCode
  );

  modport slave (
    input  rx,
    output byteData, byteValid, frameData, frameValid, frameError, errCode
  );
endinterface

// File: rtl/sync_frame_rx_uart_rx_core.sv
// 8N1 UART receive core: rx synchroniser, mid-bit sampling FSM, start/stop checks.
module sync_frame_rx_uart_rx_core
  import sync_frame_rx_pkg::*;
#(
  parameter int BAUD_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byteOk_o,
  output logic       byteBad_o,
  output logic       idle_o,
  output logic       fall_o
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

  rxState_e         state_q, state_d;
  logic             rxMeta_q, rxSync_q, rxPrev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       shift_q, shift_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
      cnt_q    <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      rxMeta_q <= rx_i;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
      cnt_q    <= cnt_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
    end
  end

  assign fall_o = rxPrev_q & ~rxSync_q;
  assign idle_o = (state_q == ST_IDLE);
  assign byte_o = shift_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    byteOk_o  = 1'b0;
    byteBad_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (fall_o) begin
          bitCnt_d = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rxSync_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d    = '0;
          shift_d  = {rxSync_q, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          state_d   = ST_IDLE;
          byteOk_o  = rxSync_q;
          byteBad_o = ~rxSync_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/sync_frame_rx.sv
// Clock-sync link receiver: assembles N_BYTES good UART bytes into one frame.
module sync_frame_rx
  import sync_frame_rx_pkg::*;
#(
  parameter int CLOCK_FREQ   = 100_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int N_BYTES      = 7,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  sync_frame_rx_if.slave bus
);

  localparam int BAUD_DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam int IDX_W    = $clog2(N_BYTES);
  localparam int FW       = 8 * N_BYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_LIMIT - 1);

  logic [7:0] coreByte;
  logic       coreOk, coreBad, coreIdle, coreFall;

  sync_frame_rx_uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_i      (bus.rx),
    .byte_o    (coreByte),
    .byteOk_o  (coreOk),
    .byteBad_o (coreBad),
    .idle_o    (coreIdle),
    .fall_o    (coreFall)
  );

  logic [7:0]       byteData_q, byteData_d;
  logic             byteValid_q, byteValid_d;
  logic [FW-1:0]    frameData_q, frameData_d;
  logic             frameValid_q, frameValid_d;
  logic             frameError_q, frameError_d;
  logic [1:0]       errCode_q, errCode_d;
  logic [FW-1:0]    buf_q, buf_d, bufNext;
  logic [IDX_W-1:0] index_q, index_d;
  logic [TO_W-1:0]  toCnt_q, toCnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byteData_q   <= '0;
      byteValid_q  <= 1'b0;
      frameData_q  <= '0;
      frameValid_q <= 1'b0;
      frameError_q <= 1'b0;
      errCode_q    <= '0;
      buf_q        <= '0;
      index_q      <= '0;
      toCnt_q      <= '0;
    end else begin
      byteData_q   <= byteData_d;
      byteValid_q  <= byteValid_d;
      frameData_q  <= frameData_d;
      frameValid_q <= frameValid_d;
      frameError_q <= frameError_d;
      errCode_q    <= errCode_d;
      buf_q        <= buf_d;
      index_q      <= index_d;
      toCnt_q      <= toCnt_d;
    end
  end

  always_comb begin
    bufNext = buf_q;
    for (int k = 0; k < N_BYTES; k++) begin
      if (index_q == IDX_W'(k)) bufNext[k*8 +: 8] = coreByte;
    end
  end

  // The timeout counter only runs between bytes of a partial frame and
  // restarts on every falling edge; it takes priority over a coincident edge.
  always_comb begin
    byteData_d   = byteData_q;
    byteValid_d  = 1'b0;
    frameData_d  = frameData_q;
    frameValid_d = 1'b0;
    frameError_d = 1'b0;
    errCode_d    = errCode_q;
    buf_d        = buf_q;
    index_d      = index_q;
    toCnt_d      = '0;
    if (coreOk) begin
      byteValid_d = 1'b1;
      byteData_d  = coreByte;
      buf_d       = bufNext;
      if (index_q == LAST_IDX) begin
        frameData_d  = bufNext;
        frameValid_d = 1'b1;
        index_d      = '0;
      end else begin
        index_d = index_q + 1'b1;
      end
    end else if (coreBad) begin
      frameError_d = 1'b1;
      errCode_d    = ERR_FRAMING;
      index_d      = '0;
    end else if (coreIdle && (index_q != '0)) begin
      if (toCnt_q == TO_LAST) begin
        frameError_d = 1'b1;
        errCode_d    = ERR_TIMEOUT;
        index_d      = '0;
      end else if (!coreFall) begin
        toCnt_d = toCnt_q + 1'b1;
      end
    end
  end

  assign bus.byteData   = byteData_q;
  assign bus.byteValid  = byteValid_q;
  assign bus.frameData  = frameData_q;
  assign bus.frameValid = frameValid_q;
  assign bus.frameError = frameError_q;
  assign bus.errCode    = errCode_q;

endmodule

// File: tb/tb_sync_frame_rx.sv
// Directed/random bench for sync_frame_rx against a byte-queue frame model.
module tb_sync_frame_rx;

  localparam int CLOCK_FREQ   = 160_000;
  localparam int BAUD_RATE    = 10_000;
  localparam int N_BYTES      = 7;
  localparam int TIMEOUT_BITS = 20;
  localparam int BAUD_DIV     = CLOCK_FREQ / BAUD_RATE;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sync_frame_rx_if #(.N_BYTES(N_BYTES)) bus ();

  sync_frame_rx #(
    .CLOCK_FREQ   (CLOCK_FREQ),
    .BAUD_RATE    (BAUD_RATE),
    .N_BYTES      (N_BYTES),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;
  int cycle       = 0;

  int          byteCount = 0, frameCount = 0, errCount = 0;
  int          lastByteCycle = 0, errCycle = 0;
  logic [7:0]  lastByteSeen = '0;
  logic [1:0]  lastErrSeen = '0;

  logic [7:0]  partial[$];
  logic [55:0] expFrame = '0;
  logic [7:0]  expLastByte = '0;
  logic [1:0]  expErr = '0;
  int          expBytes = 0, expFrames = 0, expErrs = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cycle++;

  // Passive monitor: records every pulse seen on the result bus.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.byteValid) begin
        byteCount++;
        lastByteSeen  = bus.byteData;
        lastByteCycle = cycle;
      end
      if (bus.frameValid) begin
        frameCount++;
        checkOutput("frame_with_byte", {63'd0, bus.byteValid}, 64'd1);
      end
      if (bus.frameError) begin
        errCount++;
        lastErrSeen = bus.errCode;
        errCycle    = cycle;
      end
    end
  end

  function automatic logic [55:0] packFrame(input logic [7:0] q[$]);
    logic [55:0] f = '0;
    for (int k = 0; k < q.size(); k++) f[k*8 +: 8] = q[k];
    return f;
  endfunction

  function automatic void modelGood(input logic [7:0] b);
    expBytes++;
    expLastByte = b;
    partial.push_back(b);
    if (partial.size() == N_BYTES) begin
      expFrame = packFrame(partial);
      expFrames++;
      partial.delete();
    end
  endfunction

  function automatic void modelError(input logic [1:0] code);
    expErrs++;
    expErr = code;
    partial.delete();
  endfunction

  task automatic driveBit(input logic v);
    bus.rx = v;
    repeat (BAUD_DIV) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
    driveBit(stopBit);
    if (stopBit) modelGood(b);
    else begin
      modelError(2'b01);
      driveBit(1'b1);
    end
  endtask

  task automatic sendRandomFrame();
    for (int i = 0; i < N_BYTES; i++) applyStimulus(8'($urandom_range(0, 255)), 1'b1);
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_bytes"},  64'(byteCount),  64'(expBytes));
    checkOutput({tag, "_frames"}, 64'(frameCount), 64'(expFrames));
    checkOutput({tag, "_errs"},   64'(errCount),   64'(expErrs));
    checkOutput({tag, "_fdata"},  64'(bus.frameData), 64'(expFrame));
    checkOutput({tag, "_bdata"},  64'(bus.byteData),  64'(expLastByte));
    checkOutput({tag, "_ecode"},  64'(bus.errCode),   64'(expErr));
  endtask

  initial begin
    logic [7:0] t1Bytes[7] = '{8'h24, 8'h08, 8'h18, 8'h13, 8'h21, 8'h59, 8'h06};
    logic [55:0] held;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_bvalid", {63'd0, bus.byteValid}, 64'd0);
    checkOutput("reset_fvalid", {63'd0, bus.frameValid}, 64'd0);
    checkOutput("reset_ferr",   {63'd0, bus.frameError}, 64'd0);
    checkAll("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] step 1: directed frame");
    foreach (t1Bytes[i]) applyStimulus(t1Bytes[i], 1'b1);
    repeat (40) @(negedge clk);
    checkAll("t1");
    checkOutput("t1_const", 64'(bus.frameData), 64'h06592113180824);

    $display("[TB] step 1b: random frames");
    for (int f = 0; f < 2; f++) begin
      sendRandomFrame();
      repeat (40) @(negedge clk);
      checkAll("t1b");
    end

    $display("[TB] step 2: start glitch");
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    repeat (40) @(negedge clk);
    checkAll("t2");

    $display("[TB] step 3: bad stop then frame");
    applyStimulus(8'hA5, 1'b0);
    repeat (10) @(negedge clk);
    checkAll("t3a");
    checkOutput("t3_errseen", 64'(lastErrSeen), 64'd1);
    foreach (t1Bytes[i]) applyStimulus(t1Bytes[i], 1'b1);
    repeat (40) @(negedge clk);
    checkAll("t3b");

    $display("[TB] step 4: inter-byte timeout");
    held = bus.frameData;
    for (int i = 0; i < 3; i++) applyStimulus(8'($urandom_range(0, 255)), 1'b1);
    repeat (400) @(negedge clk);
    modelError(2'b10);
    checkAll("t4");
    checkOutput("t4_delay", 64'(errCycle - lastByteCycle), 64'd320);
    checkOutput("t4_errseen", 64'(lastErrSeen), 64'd2);
    checkOutput("t4_held", 64'(bus.frameData), 64'(held));

    $display("[TB] step 5: reset mid-frame");
    for (int i = 0; i < 3; i++) applyStimulus(8'($urandom_range(1, 255)), 1'b1);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_bdata", 64'(bus.byteData), 64'd0);
    checkOutput("t5_fdata", 64'(bus.frameData), 64'd0);
    checkOutput("t5_ecode", 64'(bus.errCode), 64'd0);
    checkOutput("t5_bvalid", {63'd0, bus.byteValid}, 64'd0);
    partial.delete();
    expFrame = '0;
    expLastByte = '0;
    expErr = '0;
    @(negedge clk);
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    sendRandomFrame();
    repeat (40) @(negedge clk);
    checkAll("t5");

    $display("[TB] step 6: held-low break");
    bus.rx = 1'b0;
    repeat (30 * BAUD_DIV) @(negedge clk);
    bus.rx = 1'b1;
    modelError(2'b01);
    repeat (40) @(negedge clk);
    checkAll("t6a");
    sendRandomFrame();
    repeat (40) @(negedge clk);
    checkAll("t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
